// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer; req/ack memory port, PC-tagged FIFO, redirect and HALT handling.
// Optional FETCH_PERF_EN adds saturating perf_fetched/perf_redirects counters.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef HALT
`define HALT 5'h1f
`endif

module fetch_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int RESET_PC = 0,
  parameter int DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [`WIDTH-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [`WIDTH-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_redirects
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {RUN, STOP, HALTED} state_t;
  state_t            state, nxt_state;
  logic [`WIDTH-1:0] mem_w [DEPTH];
  logic [ADDR_W-1:0] mem_pc [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, nxt_count;
  logic [ADDR_W-1:0] pc, nxt_pc, hold_pc;
  logic [`WIDTH-1:0] hold_w;
  logic              drop, act, redir, ack, push, pop, pop_halt, flush, nxt_req;
  assign act       = state != HALTED;
  assign redir     = redirect_valid && act;
  assign ack       = imem_req && imem_ack && act;
  assign push      = ack && !drop && !redir;
  assign inst_valid = count != '0;
  assign inst      = inst_valid ? mem_w[rd_ptr] : hold_w;
  assign inst_pc   = inst_valid ? mem_pc[rd_ptr] : hold_pc;
  assign pop       = inst_valid && inst_ready;
  assign pop_halt  = pop && inst[31:27] == `HALT;
  assign flush     = redir || pop_halt;
  assign halted    = state == HALTED;
  always_comb begin
    nxt_state = pop_halt ? HALTED : redir ? RUN :
                (push && imem_rdata[31:27] == `HALT) ? STOP : state;
    nxt_count = flush ? '0 : count + CW'(push) - CW'(pop);
    nxt_pc    = redir ? redirect_pc : push ? imem_addr + ADDR_W'(1) : pc;
    // an outstanding request stays up until acked; a fresh one needs a free slot
    nxt_req   = nxt_state != HALTED &&
                (imem_req ? !imem_ack : (nxt_state == RUN && nxt_count < CW'(DEPTH)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= ADDR_W'(RESET_PC);
      imem_addr <= ADDR_W'(RESET_PC);
      imem_req  <= 1'b0;
      drop      <= 1'b0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      hold_w    <= '0;
      hold_pc   <= '0;
    end else begin
      state    <= nxt_state;
      pc       <= nxt_pc;
      count    <= nxt_count;
      imem_req <= nxt_req;
      if (!imem_req) imem_addr <= nxt_pc;
      drop     <= ack ? 1'b0 : (redir && imem_req) ? 1'b1 : drop;
      rd_ptr   <= flush ? '0 : rd_ptr + PW'(pop);
      wr_ptr   <= flush ? '0 : wr_ptr + PW'(push);
      if (inst_valid) begin
        hold_w  <= inst;
        hold_pc <= inst_pc;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_w[wr_ptr]  <= imem_rdata;
      mem_pc[wr_ptr] <= imem_addr;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'(perf_fetched != '1);
      if (redir) perf_redirects <= perf_redirects + 32'(perf_redirects != '1);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed tests with a queue-based reference model checked every cycle.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef HALT
`define HALT 5'h1f
`endif

module tb_fetch_ctrl;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 0;
  logic imem_req, imem_ack = 0, redirect_valid = 0, inst_valid, inst_ready = 0, halted;
  logic [15:0] imem_addr, redirect_pc = 0, inst_pc;
  logic [`WIDTH-1:0] imem_rdata = 0, inst;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_redirects;
  int mf, mr;
`endif
  fetch_ctrl #(.ADDR_W(16), .RESET_PC(0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .halted(halted)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_redirects(perf_redirects)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {logic [31:0] w; logic [15:0] pc;} ent_t;
  ent_t mq[$];
  ent_t m_last;
  int m_state;
  logic m_req, m_drop;
  logic [15:0] m_addr, m_pc;
  int total = 0, bad = 0, cyc = 0;
  int halt_addr = -1, stop_addr = -1, pop_cyc = -1, halt_cyc = -1;
  logic [15:0] acks[$], pops[$];
  int ack_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [15:0] a);
    return (int'(a) == halt_addr) ? {`HALT, 11'h0, a} : {5'h01, 11'h0, a};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = '{32'h0, 16'h0};
    m_state = 0; m_req = 0; m_drop = 0; m_addr = 0; m_pc = 0;
`ifdef FETCH_PERF_EN
    mf = 0; mr = 0;
`endif
  endtask

  // state: 0 fetching, 1 HALT fetched, 2 halted
  task automatic model_step();
    ent_t e;
    bit ackd, pop_h;
    if (m_state == 2) return;
    ackd = m_req && imem_ack;
    pop_h = 0;
    if (mq.size() > 0 && inst_ready) begin
      e = mq.pop_front();
      pop_h = e.w[31:27] == `HALT;
    end
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc;
      m_state = 0;
      m_drop = m_req && !imem_ack;
`ifdef FETCH_PERF_EN
      if (mr != -1) mr++;
`endif
    end else if (ackd) begin
      if (!m_drop) begin
        mq.push_back('{imem_rdata, m_addr});
        m_pc = m_addr + 16'd1;
        if (imem_rdata[31:27] == `HALT) m_state = 1;
`ifdef FETCH_PERF_EN
        if (mf != -1) mf++;
`endif
      end
      m_drop = 0;
    end
    if (pop_h) begin
      m_state = 2;
      mq.delete();
    end
    if (m_req) m_req = !imem_ack;
    else if (m_state == 0 && mq.size() < DEPTH) begin
      m_req = 1;
      m_addr = m_pc;
    end
    if (m_state == 2) m_req = 0;
  endtask

  task automatic compare();
    chk("req", imem_req, m_req);
    if (m_req) chk("addr", imem_addr, m_addr);
    chk("valid", inst_valid, mq.size() > 0);
    if (mq.size() > 0) m_last = mq[0];
    chk("inst", inst, m_last.w);
    chk("inst_pc", inst_pc, m_last.pc);
    chk("halted", halted, m_state == 2);
    if (halted && halt_cyc < 0) halt_cyc = cyc;
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, mf);
    chk("perf_redirects", perf_redirects, mr);
`endif
  endtask

  // called just after a negedge with inputs final; returns at the next negedge
  task automatic tick();
    cyc++;
    if (inst_valid && inst_ready) begin
      pops.push_back(inst_pc);
      if (inst_pc == 16'd3 && inst[31:27] == `HALT) pop_cyc = cyc;
    end
    if (imem_ack) begin
      acks.push_back(imem_addr);
      ack_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    @(negedge clk);
    compare();
    redirect_valid = 0;
    imem_ack = 0;
    if (imem_req && int'(imem_addr) != stop_addr) begin
      imem_ack = 1;
      imem_rdata = word_at(imem_addr);
    end
  endtask

  task automatic clear_traces();
    acks.delete(); pops.delete(); ack_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 0;
    imem_ack = 0;
    model_reset();
    tick();
    tick();
    rst_n = 1;
    clear_traces();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 16'h0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 16'h0);
    chk("rst_halted", halted, 1'b0);

    // straight-line fetch
    inst_ready = 1;
    repeat (9) tick();
    for (int i = 0; i < 4; i++) begin
      chk("line_ack_addr", acks[i], 16'(i));
      chk("line_pop_pc", pops[i], 16'(i));
    end
    chk("line_cadence", ack_cyc[3] - ack_cyc[0], 6);

    // backpressure
    inst_ready = 0;
    do_reset();
    repeat (10) tick();
    chk("bp_acks", acks.size(), 2);
    chk("bp_req", imem_req, 1'b0);
    chk("bp_valid", inst_valid, 1'b1);
    chk("bp_head", inst_pc, 16'h0);
    inst_ready = 1;
    clear_traces();
    repeat (6) tick();
    chk("bp_pop0", pops[0], 16'h0);
    chk("bp_pop1", pops[1], 16'h1);
    chk("bp_resume", acks[0], 16'h2);

    // redirect while a request is outstanding
    do_reset();
    stop_addr = 5;
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 16'h5); i++) tick();
    chk("rd_reach5", imem_req && imem_addr == 16'h5, 1'b1);
    redirect_valid = 1;
    redirect_pc = 16'h40;
    clear_traces();
    tick();
    tick();
    stop_addr = -1;
    repeat (8) tick();
    chk("rd_stale_ack", acks[0], 16'h5);
    chk("rd_next_addr", acks[1], 16'h40);
    chk("rd_first_pc", pops[0], 16'h40);

    // redirect coincident with ack
    do_reset();
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 16'h7); i++) tick();
    chk("ra_reach7", imem_ack && imem_addr == 16'h7, 1'b1);
    redirect_valid = 1;
    redirect_pc = 16'h10;
    clear_traces();
    tick();
    chk("ra_empty", inst_valid, 1'b0);
    for (int i = 0; i < 10 && !imem_req; i++) tick();
    chk("ra_next_addr", imem_addr, 16'h10);
    repeat (4) tick();
    chk("ra_first_pc", pops[0], 16'h10);

    // halt
    do_reset();
    halt_addr = 3;
    halt_cyc = -1;
    pop_cyc = -1;
    repeat (14) tick();
    chk("h_acks", acks.size(), 4);
    chk("h_last_pop", pops[pops.size()-1], 16'h3);
    chk("h_halted", halted, 1'b1);
    chk("h_timing", halt_cyc - pop_cyc, 0);
    redirect_valid = 1;
    redirect_pc = 16'h20;
    repeat (4) tick();
    chk("h_stay", halted, 1'b1);
    chk("h_noreq", imem_req, 1'b0);
    chk("h_noacks", acks.size(), 4);
    halt_addr = -1;

    // async reset mid-fetch
    do_reset();
    inst_ready = 0;
    stop_addr = 1;
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 16'h1); i++) tick();
    chk("ar_pending", inst_valid && imem_req, 1'b1);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("ar_req", imem_req, 1'b0);
    chk("ar_valid", inst_valid, 1'b0);
    chk("ar_halted", halted, 1'b0);
    @(negedge clk);
    imem_ack = 0;
    tick();
    stop_addr = -1;
    rst_n = 1;
    clear_traces();
    tick();
    chk("ar_first_req", imem_req, 1'b1);
    chk("ar_first_addr", imem_addr, 16'h0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
